// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS instruction fetch stage with IF/ID register, skid buffer, branch redirect and halt
module mips_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    input  logic        ID_EX_MemReadEn,
    input  logic [4:0]  ID_EX_Rdest,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_PC,
    output logic        stall,
    output logic        active
);

    typedef enum logic [0:0] {S_FETCH, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc_q;
    logic        skid_valid_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        squash_q;
    logic [31:0] squash_target_q;

    logic halt_now;
    logic accept;
    logic drop;

    // A pending squash means the current PC is a read about to be thrown away, not a real halt.
    assign halt_now = (pc_q == HALT_ADDR) && !squash_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_FETCH && halt_now)
            state_d = S_HALTED;
    end

    always_comb begin
        instr_read = !reset && (state_q == S_FETCH) && !skid_valid_q && !halt_now;
        active     = reset || (state_q == S_FETCH);
    end

    assign stall = ID_EX_MemReadEn && (ID_EX_Rdest != 5'd0) && if_id_valid_q &&
                   ((ID_EX_Rdest == if_id_instr_q[25:21]) || (ID_EX_Rdest == if_id_instr_q[20:16]));

    assign accept = instr_read && !instr_waitrequest;
    assign drop   = accept && (branch_taken || squash_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_VECTOR;
            if_id_valid_q   <= 1'b0;
            if_id_instr_q   <= 32'd0;
            if_id_pc_q      <= 32'd0;
            skid_valid_q    <= 1'b0;
            skid_instr_q    <= 32'd0;
            skid_pc_q       <= 32'd0;
            squash_q        <= 1'b0;
            squash_target_q <= 32'd0;
        end else begin
            if (accept) begin
                squash_q <= 1'b0;
                if (branch_taken)  pc_q <= branch_target;
                else if (squash_q) pc_q <= squash_target_q;
                else               pc_q <= pc_q + 32'd4;
            end else if (branch_taken && instr_read) begin
                // Read in flight: the address must stay put, so remember where to go afterwards.
                squash_q        <= 1'b1;
                squash_target_q <= branch_target;
            end else if (branch_taken) begin
                pc_q <= branch_target;
            end

            if (!stall) begin
                skid_valid_q <= 1'b0;
                if (skid_valid_q && !branch_taken) begin
                    if_id_valid_q <= 1'b1;
                    if_id_instr_q <= skid_instr_q;
                    if_id_pc_q    <= skid_pc_q;
                end else if (accept && !drop) begin
                    if_id_valid_q <= 1'b1;
                    if_id_instr_q <= instr_readdata;
                    if_id_pc_q    <= pc_q;
                end else begin
                    if_id_valid_q <= 1'b0;
                end
            end else if (accept && !drop) begin
                skid_valid_q <= 1'b1;
                skid_instr_q <= instr_readdata;
                skid_pc_q    <= pc_q;
            end
        end
    end

    assign instr_address     = pc_q;
    assign IF_ID_Instruction = if_id_instr_q;
    assign IF_ID_PC          = if_id_pc_q;
    assign IF_ID_valid       = if_id_valid_q & ~stall;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed bench for mips_fetch_stage with a program-order delivery model
module tb_mips_fetch_stage;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic        ID_EX_MemReadEn;
    logic [4:0]  ID_EX_Rdest;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_valid;
    logic [31:0] IF_ID_PC;
    logic        stall;
    logic        active;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_pc = RV;
    int          delivered = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always #5 clk = ~clk;

    mips_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .ID_EX_MemReadEn   (ID_EX_MemReadEn),
        .ID_EX_Rdest       (ID_EX_Rdest),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_valid       (IF_ID_valid),
        .IF_ID_PC          (IF_ID_PC),
        .stall             (stall),
        .active            (active)
    );

    // Program memory: addu $3,$2,$4 at BFC0000C, elsewhere addi with rs=rt=0 tagged by address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0000C) return 32'h00441821;
        return {6'h08, 10'd0, a[15:0]};
    endfunction

    assign instr_readdata = mem_word(instr_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Delivered instructions must follow program order with one delay slot after each taken branch.
    always @(negedge clk) begin
        if (reset) begin
            exp_pc    = RV;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_read", {31'd0, instr_read}, 32'd1);
                chk("hold_addr", instr_address, prev_addr);
            end
            if (IF_ID_valid) begin
                chk("model_pc", IF_ID_PC, exp_pc);
                chk("model_instr", IF_ID_Instruction, mem_word(exp_pc));
                delivered++;
                exp_pc = branch_taken ? branch_target : exp_pc + 32'd4;
            end
            prev_hold = instr_read && instr_waitrequest;
            prev_addr = instr_address;
        end
    end

    task automatic tick(input logic w, input logic mr, input logic [4:0] rd,
                        input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        instr_waitrequest = w;
        ID_EX_MemReadEn   = mr;
        ID_EX_Rdest       = rd;
        branch_taken      = br;
        branch_target     = tgt;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        instr_waitrequest = 1'b0;
        ID_EX_MemReadEn   = 1'b0;
        ID_EX_Rdest       = 5'd0;
        branch_taken      = 1'b0;
        branch_target     = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_read", {31'd0, instr_read}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_ifid_pc", IF_ID_PC, 32'd0);
        chk("rst_ifid_instr", IF_ID_Instruction, 32'd0);
        chk("rst_addr", instr_address, RV);

        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);                                      // c0
        chk("c0_read", {31'd0, instr_read}, 32'd1);
        tick(1, 0, 0, 0, 0);                                 // c1
        chk("c1_addr", instr_address, 32'hBFC00004);
        chk("c1_pc", IF_ID_PC, 32'hBFC00000);
        chk("c1_valid", {31'd0, IF_ID_valid}, 32'd1);
        for (int i = 2; i <= 4; i++) begin                   // c2..c4
            tick(i < 4, 0, 0, 0, 0);
            chk("wait_valid", {31'd0, IF_ID_valid}, 32'd0);
            chk("wait_addr", instr_address, 32'hBFC00004);
        end
        tick(0, 1, 5'd0, 0, 0);                              // c5
        chk("c5_pc", IF_ID_PC, 32'hBFC00004);
        chk("c5_rd0_stall", {31'd0, stall}, 32'd0);
        chk("c5_addr", instr_address, 32'hBFC00008);
        tick(0, 1, 5'd3, 0, 0);                              // c6
        chk("c6_stall", {31'd0, stall}, 32'd0);
        tick(0, 1, 5'd2, 0, 0);                              // c7
        chk("c7_stall_rs", {31'd0, stall}, 32'd1);
        chk("c7_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("c7_pc", IF_ID_PC, 32'hBFC0000C);
        tick(0, 1, 5'd4, 0, 0);                              // c8
        chk("c8_stall_rt", {31'd0, stall}, 32'd1);
        chk("c8_read_skid", {31'd0, instr_read}, 32'd0);
        tick(0, 0, 0, 0, 0);                                 // c9
        chk("c9_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("c9_pc", IF_ID_PC, 32'hBFC0000C);
        chk("c9_instr", IF_ID_Instruction, 32'h00441821);
        chk("c9_read", {31'd0, instr_read}, 32'd0);
        tick(0, 0, 0, 0, 0);                                 // c10
        chk("c10_pc_skid", IF_ID_PC, 32'hBFC00010);
        chk("c10_addr", instr_address, 32'hBFC00014);
        tick(0, 0, 0, 1, 32'hBFC00100);                      // c11
        chk("c11_delay_pc", IF_ID_PC, 32'hBFC00014);
        chk("c11_delay_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("c11_addr", instr_address, 32'hBFC00018);
        tick(0, 0, 0, 0, 0);                                 // c12
        chk("c12_addr_tgt", instr_address, 32'hBFC00100);
        chk("c12_dropped", {31'd0, IF_ID_valid}, 32'd0);
        tick(1, 0, 0, 1, 32'hBFC00200);                      // c13
        chk("c13_pc", IF_ID_PC, 32'hBFC00100);
        tick(1, 0, 0, 0, 0);                                 // c14
        chk("c14_addr", instr_address, 32'hBFC00104);
        chk("c14_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick(0, 0, 0, 0, 0);                                 // c15
        chk("c15_addr", instr_address, 32'hBFC00104);
        tick(0, 0, 0, 0, 0);                                 // c16
        chk("c16_addr_tgt", instr_address, 32'hBFC00200);
        chk("c16_squashed", {31'd0, IF_ID_valid}, 32'd0);
        tick(0, 0, 0, 1, 32'h00000000);                      // c17
        chk("c17_pc", IF_ID_PC, 32'hBFC00200);
        tick(0, 0, 0, 0, 0);                                 // c18
        chk("c18_addr", instr_address, 32'h00000000);
        chk("c18_read", {31'd0, instr_read}, 32'd0);
        tick(0, 0, 0, 0, 0);                                 // c19
        chk("halt_active", {31'd0, active}, 32'd0);
        chk("halt_read", {31'd0, instr_read}, 32'd0);
        tick(0, 0, 0, 0, 0);                                 // c20
        chk("halt_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("model_delivered", delivered, 32'd8);
        chk("model_exp_pc", exp_pc, 32'h00000000);

        @(posedge clk); #1; reset = 1'b1;                    // c21
        @(negedge clk);
        chk("rst2_read", {31'd0, instr_read}, 32'd0);
        chk("rst2_active", {31'd0, active}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;                    // c22
        @(negedge clk);
        chk("rst2_addr", instr_address, RV);
        chk("rst2_read1", {31'd0, instr_read}, 32'd1);
        tick(0, 0, 0, 0, 0);                                 // c23
        chk("rst2_pc", IF_ID_PC, RV);
        chk("rst2_valid", {31'd0, IF_ID_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
